serial_frame_receiver: RTL
==========================

Name: serial_frame_receiver

Overview:
- Receive end of the single-bit registered serial path.
- Samples a 1-bit stream on every clock and hunts for a sync word.
- After lock, deserializes FRAME_LEN data words, MSB first, into a one-entry output holding register with a valid/ready handshake.
- Pure standard-cell flop/gate logic, intended as a multi-stage sequential timing target alongside the transmit-side pipeline designs.

Parameters:
- DATA_W, 8, bits per data word.
- SYNC_W, 8, bits in the sync word.
- SYNC_WORD, 8'hA5, sync pattern, MSB received first.
- FRAME_LEN, 4, data words per frame after sync.

Ports:
- clk  input  1  clock, all flops rising-edge.
- reset  input  1  synchronous, active-high reset.
- sin  input  1  serial data, one bit sampled per clk.
- data_out  output  DATA_W  received word in the holding register.
- data_valid  output  1  holding register contains an unconsumed word.
- data_ready  input  1  consumer accepts data_out when data_valid=1.
- sync_locked  output  1  high while in state DATA.
- frame_done  output  1  one-cycle pulse when the last word of a frame is loaded.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values (takes effect on the next clk edge while reset=1): data_out=0, data_valid=0, sync_locked=0, frame_done=0, overflow=0, state=HUNT, all counters and the shift register cleared.
- Shift register: SYNC_W-bit, new bit enters at LSB, so the first-received bit ends at MSB. The data path uses the same register's low DATA_W bits.

State HUNT:
- Shift sin every cycle.
- hunt_cnt counts bits since entering HUNT, saturating at SYNC_W.
- Match condition: hunt_cnt reaches SYNC_W (including the bit shifted this cycle) AND the shift register value after the shift equals SYNC_WORD.
- On match, go to DATA next cycle with bit_cnt=0 and word_cnt=0.
- The hunt_cnt gate prevents stale or cleared bits matching, including when SYNC_WORD=0.

State DATA:
- Shift sin every cycle; bit_cnt increments.
- When bit_cnt=DATA_W-1, the completed word is the post-shift value. bit_cnt wraps to 0 and word_cnt increments.
- Load rule, evaluated in the cycle the word completes:
  - If data_valid=0, or data_ready=1, load data_out and set data_valid=1 on the next edge.
  - Otherwise drop the word, keep data_out, and set overflow=1.
- Latency: data_valid/data_out update on the clk edge that samples the final bit, so they are visible in the cycle after the last bit is presented.
- Handshake: a transfer occurs on any edge where data_valid=1 and data_ready=1. data_valid clears on that edge unless a new word loads on the same edge, in which case data_valid stays 1 and data_out takes the new word.
- End of frame: when word_cnt reaches FRAME_LEN-1 and the word completes:
  - frame_done=1 for exactly one cycle, coincident with that word's load opportunity. It pulses even if the word is dropped.
  - State returns to HUNT and hunt_cnt=0.
- sync_locked is registered, equal to (state==DATA); it falls in the same cycle frame_done pulses.
- overflow: once set, cleared only by reset.
- data_ready: ignored while data_valid=0.
- Reset mid-frame: any held word is discarded and data_valid=0. A full new sync word is required; pre-reset bits never contribute to a match.
- Back-to-back frames: the next sync word may start on the bit immediately after the last data bit.
- Counter widths: bit_cnt ceil(log2(DATA_W)), word_cnt ceil(log2(FRAME_LEN)), hunt_cnt ceil(log2(SYNC_W+1)); no other wrap behaviour.

Test Plan:
- Reset: reset=1 for 3 cycles with sin toggling -> all outputs 0; then send 8 zeros -> sync_locked stays 0.
- Nominal frame, data_ready=1: send A5 then 11,22,33,44 MSB first -> sync_locked rises 1 cycle after A5's last bit. data_valid pulses 1 cycle each with 11,22,33,44, the cycle after each 8th bit. frame_done coincides with 44 and sync_locked falls then. overflow=0.
- Misaligned hunt: send 5A,3C, then 3 junk bits 101, then A5, 11,22,33,44 -> no lock before A5 completes; lock exactly after A5's 8th bit; correct words follow.
- Backpressure: data_ready=0 for the whole frame -> data_out=11 held with data_valid=1; overflow sets when 22 completes and stays 1 after the frame. Raising data_ready afterwards clears data_valid, and data_out remains 11.
- Simultaneous accept/load: hold 11 and raise data_ready only in the cycle 22 completes -> data_out=22, data_valid stays 1, overflow=0.
- Reset mid-frame: reset for 1 cycle after 2 words (11,22 held) -> outputs 0 and HUNT. Then send 33,44 -> no lock. Then send A5, 55,66,77,88 -> those four words are received.

Source files
------------

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: hunts a 1-bit stream for a sync word, then deserializes
// FRAME_LEN MSB-first words into a single holding register with valid/ready.
module serial_frame_receiver #(
    parameter int                DATA_W    = 8,
    parameter int                SYNC_W    = 8,
    parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA5,
    parameter int                FRAME_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sin,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              sync_locked,
    output logic              frame_done,
    output logic              overflow
);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int WORD_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int HUNT_W = $clog2(SYNC_W + 1);

    typedef enum logic {HUNT, DATA} state_t;

    state_t              state_reg, state_next;
    logic [SYNC_W-1:0]   shift_reg, shift_next;
    logic [HUNT_W-1:0]   hunt_cnt_reg, hunt_cnt_next, hunt_cnt_inc;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0]   word_cnt_reg, word_cnt_next;
    logic [DATA_W-1:0]   data_out_reg, data_out_next;
    logic                data_valid_reg, data_valid_next;
    logic                sync_locked_reg, sync_locked_next;
    logic                frame_done_reg, frame_done_next;
    logic                overflow_reg, overflow_next;
    logic                match, word_done, last_word, load;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= HUNT;
            shift_reg       <= '0;
            hunt_cnt_reg    <= '0;
            bit_cnt_reg     <= '0;
            word_cnt_reg    <= '0;
            data_out_reg    <= '0;
            data_valid_reg  <= 1'b0;
            sync_locked_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shift_reg       <= shift_next;
            hunt_cnt_reg    <= hunt_cnt_next;
            bit_cnt_reg     <= bit_cnt_next;
            word_cnt_reg    <= word_cnt_next;
            data_out_reg    <= data_out_next;
            data_valid_reg  <= data_valid_next;
            sync_locked_reg <= sync_locked_next;
            frame_done_reg  <= frame_done_next;
            overflow_reg    <= overflow_next;
        end
    end

    // The hunt counter gate keeps cleared or stale shift bits from ever matching.
    always_comb begin
        shift_next   = {shift_reg[SYNC_W-2:0], sin};
        hunt_cnt_inc = (hunt_cnt_reg == HUNT_W'(SYNC_W)) ? hunt_cnt_reg
                                                          : hunt_cnt_reg + HUNT_W'(1);
        match        = (hunt_cnt_inc == HUNT_W'(SYNC_W)) && (shift_next == SYNC_WORD);
        word_done    = (bit_cnt_reg == BIT_W'(DATA_W - 1));
        last_word    = word_done && (word_cnt_reg == WORD_W'(FRAME_LEN - 1));
        state_next   = state_reg;
        case (state_reg)
            HUNT:    if (match)     state_next = DATA;
            DATA:    if (last_word) state_next = HUNT;
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        hunt_cnt_next    = hunt_cnt_reg;
        bit_cnt_next     = bit_cnt_reg;
        word_cnt_next    = word_cnt_reg;
        data_out_next    = data_out_reg;
        data_valid_next  = data_valid_reg && !data_ready;
        frame_done_next  = 1'b0;
        overflow_next    = overflow_reg;
        load             = 1'b0;
        sync_locked_next = (state_next == DATA);
        case (state_reg)
            HUNT: begin
                hunt_cnt_next = match ? '0 : hunt_cnt_inc;
                bit_cnt_next  = '0;
                word_cnt_next = '0;
            end
            DATA: begin
                bit_cnt_next = word_done ? '0 : bit_cnt_reg + BIT_W'(1);
                if (word_done) begin
                    load          = !data_valid_reg || data_ready;
                    word_cnt_next = last_word ? '0 : word_cnt_reg + WORD_W'(1);
                    if (load) begin
                        data_out_next   = shift_next[DATA_W-1:0];
                        data_valid_next = 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
                    if (last_word) begin
                        frame_done_next = 1'b1;
                        hunt_cnt_next   = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign data_out    = data_out_reg;
    assign data_valid  = data_valid_reg;
    assign sync_locked = sync_locked_reg;
    assign frame_done  = frame_done_reg;
    assign overflow    = overflow_reg;
endmodule
